// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin 8:1 packet arbiter with one registered output stage
// Define MUX8_ARB_TIMEOUT_EN to build the stalled-grant timeout release.
module mux8_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int TO_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         req_valid,
  input  logic [8*WIDTH-1:0] req_data,
  input  logic [7:0]         req_last,
  output logic [7:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_src,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] sel, ptr, winner, cand;
  logic       found, any_req, sel_valid, out_free, accept, release_pkt, to_fire;

  if (TO_CYCLES < 2) begin : g_bad_to_cycles
    $error("TO_CYCLES must be at least 2");
  end

  assign any_req     = |req_valid;
  assign sel_valid   = req_valid[sel];
  assign out_free    = !out_valid || out_ready;
  assign accept      = (state == LOCK) && sel_valid && out_free;
  assign release_pkt = (accept && req_last[sel]) || to_fire;

  // Search starts just after the last packet owner; 3-bit overflow gives the modulo-8 wrap.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOCK;
      LOCK:    if (release_pkt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state == LOCK);
    if (state == LOCK && out_free) req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel       <= 3'd0;
      ptr       <= 3'd7;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 3'd0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && any_req) sel <= winner;
      if (release_pkt) ptr <= sel;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= req_data[sel*WIDTH +: WIDTH];
        out_src   <= sel;
        out_last  <= req_last[sel];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam int            CW      = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] stall_cnt;

  assign to_fire = (state == LOCK) && !sel_valid && (stall_cnt == TO_LAST);

  // Counts only cycles where the owner is silent; backpressure stalls hold the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= to_fire;
      if (state != LOCK || accept || to_fire) stall_cnt <= '0;
      else if (!sel_valid)                     stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [7:0]     req_valid;
  logic [8*W-1:0] req_data;
  logic [7:0]     req_last;
  logic [7:0]     req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_src;
  logic           out_last;
  logic           out_ready;
  logic           busy;
  logic           timeout;

  int tests = 0;
  int fails = 0;

  mux8_rr_arbiter #(.WIDTH(W), .TO_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [W-1:0] v);
    req_data[idx*W +: W] = v;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 8'($urandom);
    req_last  = 8'($urandom);
    out_ready = 1'($urandom);
    for (int i = 0; i < 8; i++) set_data(i, 32'($urandom));
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (req_ready !== 8'h00) begin fails++; $display("FAIL reset_req_ready: got %h want 00", req_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (out_src !== 3'd0) begin fails++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
    tick();
    tests++; if (out_data !== 32'h0 || out_last !== 1'b0 || timeout !== 1'b0)
      begin fails++; $display("FAIL reset_payload: got data=%h last=%b to=%b want 0/0/0", out_data, out_last, timeout); end
    tests++; if (busy !== 1'b0 || req_ready !== 8'h00)
      begin fails++; $display("FAIL reset_held: got busy=%b ready=%h want 0/00", busy, req_ready); end
  endtask

  task automatic test_grant_packet();
    do_reset();
    req_valid = 8'h24;
    set_data(2, 32'hAAAA_0001);
    #1;
    tests++; if (req_ready !== 8'h00 || busy !== 1'b0)
      begin fails++; $display("FAIL arb_cycle: got ready=%h busy=%b want 00/0", req_ready, busy); end
    tick();
    tests++; if (req_ready !== 8'h04 || busy !== 1'b1)
      begin fails++; $display("FAIL grant2: got ready=%h busy=%b want 04/1", req_ready, busy); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA_0001 || out_src !== 3'd2 || out_last !== 1'b0)
      begin fails++; $display("FAIL beat_a: got v=%b d=%h s=%0d l=%b want 1/aaaa0001/2/0", out_valid, out_data, out_src, out_last); end
    set_data(2, 32'hBBBB_0002);
    tick();
    tests++; if (out_data !== 32'hBBBB_0002 || out_last !== 1'b0)
      begin fails++; $display("FAIL beat_b: got d=%h l=%b want bbbb0002/0", out_data, out_last); end
    set_data(2, 32'hCCCC_0003);
    req_last = 8'h04;
    tick();
    tests++; if (out_data !== 32'hCCCC_0003 || out_last !== 1'b1 || out_src !== 3'd2)
      begin fails++; $display("FAIL beat_c: got d=%h l=%b s=%0d want cccc0003/1/2", out_data, out_last, out_src); end
    tests++; if (busy !== 1'b0 || req_ready !== 8'h00)
      begin fails++; $display("FAIL after_last: got busy=%b ready=%h want 0/00", busy, req_ready); end
    req_valid = 8'h20;
    req_last  = 8'h00;
    tick();
    tests++; if (req_ready !== 8'h20 || out_valid !== 1'b0)
      begin fails++; $display("FAIL next_grant5: got ready=%h v=%b want 20/0", req_ready, out_valid); end
    req_valid = 8'h00;
  endtask

  task automatic test_rotation();
    logic [2:0] exp_src;
    do_reset();
    req_valid = 8'hFF;
    req_last  = 8'hFF;
    for (int i = 0; i < 8; i++) set_data(i, 32'hA0 + 32'(i));
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k % 2 == 0) begin
        exp_src = 3'((k / 2 - 1) % 8);
        tests++; if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== 32'hA0 + 32'(exp_src))
          begin fails++; $display("FAIL rotate_k%0d: got v=%b s=%0d d=%h want 1/%0d", k, out_valid, out_src, out_data, exp_src); end
      end else begin
        tests++; if (out_valid !== 1'b0)
          begin fails++; $display("FAIL rotate_gap_k%0d: got v=%b want 0", k, out_valid); end
      end
    end
    req_valid = 8'h00;
    req_last  = 8'h00;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 8'h40;
    set_data(6, 32'hD000_0000);
    tick();
    tick();
    set_data(6, 32'hD000_0001);
    out_ready = 1'b0;
    #1;
    tests++; if (req_ready !== 8'h00)
      begin fails++; $display("FAIL bp_ready: got %h want 00", req_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || out_data !== 32'hD000_0000 || req_ready !== 8'h00)
        begin fails++; $display("FAIL bp_hold_%0d: got v=%b d=%h r=%h want 1/d0000000/00", i, out_valid, out_data, req_ready); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 8'h40)
      begin fails++; $display("FAIL bp_release: got %h want 40", req_ready); end
    tick();
    tests++; if (out_data !== 32'hD000_0001 || out_valid !== 1'b1)
      begin fails++; $display("FAIL bp_beat1: got d=%h v=%b want d0000001/1", out_data, out_valid); end
    set_data(6, 32'hD000_0002);
    req_last = 8'h40;
    tick();
    tests++; if (out_data !== 32'hD000_0002 || out_last !== 1'b1)
      begin fails++; $display("FAIL bp_beat2: got d=%h l=%b want d0000002/1", out_data, out_last); end
    req_valid = 8'h00;
    req_last  = 8'h00;
    tick();
    tests++; if (out_valid !== 1'b0)
      begin fails++; $display("FAIL bp_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_stall_wait();
    do_reset();
    req_valid = 8'h10;
    set_data(4, 32'hF000_0000);
    tick();
    tick();
    req_valid = 8'h02;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (busy !== 1'b1 || req_ready !== 8'h10 || timeout !== 1'b0)
        begin fails++; $display("FAIL stall_%0d: got busy=%b r=%h to=%b want 1/10/0", i, busy, req_ready, timeout); end
    end
    req_valid = 8'h12;
    req_last  = 8'h10;
    set_data(4, 32'hF000_0001);
    tick();
    tests++; if (out_data !== 32'hF000_0001 || out_last !== 1'b1 || out_src !== 3'd4 || busy !== 1'b0)
      begin fails++; $display("FAIL stall_resume: got d=%h l=%b s=%0d busy=%b want f0000001/1/4/0", out_data, out_last, out_src, busy); end
    req_valid = 8'h02;
    req_last  = 8'h00;
    tick();
    tests++; if (req_ready !== 8'h02)
      begin fails++; $display("FAIL stall_next_grant: got %h want 02", req_ready); end
    req_valid = 8'h00;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_valid = 8'h02;
    req_last  = 8'h02;
    tick();
    tick();
    req_valid = 8'h08;
    req_last  = 8'h00;
    set_data(3, 32'hE000_0000);
    tick();
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hE000_0000 || out_src !== 3'd3)
      begin fails++; $display("FAIL mr_beat1: got v=%b d=%h s=%0d want 1/e0000000/3", out_valid, out_data, out_src); end
    set_data(3, 32'hE000_0001);
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 8'h00)
      begin fails++; $display("FAIL mr_clear: got v=%b busy=%b r=%h want 0/0/00", out_valid, busy, req_ready); end
    tick();
    reset_n   = 1'b1;
    req_valid = 8'h09;
    #1;
    tests++; if (req_ready !== 8'h00)
      begin fails++; $display("FAIL mr_arb: got %h want 00", req_ready); end
    tick();
    tests++; if (req_ready !== 8'h01)
      begin fails++; $display("FAIL mr_restart0: got %h want 01", req_ready); end
    req_valid = 8'h00;
  endtask

`ifdef MUX8_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_valid = 8'h10;
    tick();
    tick();
    req_valid = 8'h02;
    for (int i = 1; i <= 15; i++) begin
      tick();
      tests++; if (timeout !== 1'b0 || busy !== 1'b1)
        begin fails++; $display("FAIL to_early_%0d: got to=%b busy=%b want 0/1", i, timeout, busy); end
    end
    tick();
    tests++; if (timeout !== 1'b1 || busy !== 1'b0)
      begin fails++; $display("FAIL to_pulse: got to=%b busy=%b want 1/0", timeout, busy); end
    tick();
    tests++; if (timeout !== 1'b0 || req_ready !== 8'h02)
      begin fails++; $display("FAIL to_regrant: got to=%b r=%h want 0/02", timeout, req_ready); end
    req_valid = 8'h00;
  endtask
`else
  task automatic test_timeout();
    do_reset();
    req_valid = 8'h10;
    tick();
    tick();
    req_valid = 8'h02;
    for (int i = 1; i <= 20; i++) tick();
    tests++; if (timeout !== 1'b0 || busy !== 1'b1 || req_ready !== 8'h10)
      begin fails++; $display("FAIL no_timeout: got to=%b busy=%b r=%h want 0/1/10", timeout, busy, req_ready); end
    req_valid = 8'h00;
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    test_reset();
    test_grant_packet();
    test_rotation();
    test_backpressure();
    test_stall_wait();
    test_mid_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
